// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional misaligned-branch trap is enabled with IFU_MISALIGN_TRAP_EN.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } ifu_state_e;

    localparam int unsigned PC_INC = 4;
    localparam int INSTR_W         = 32;

    // Instruction field bit positions used by the decode-side parser
    localparam int OPCODE_MSB     = 6;
    localparam int OPCODE_LSB     = 0;
    localparam int FUNCT3_MSB     = 14;
    localparam int FUNCT3_LSB     = 12;
    localparam int FUNCT7_ALT_BIT = 30;

endpackage

// File: rtl/instruction_parser.sv
// Combinational extraction of the opcode and control-unit funct field
// from a 32-bit instruction word.
module instruction_parser
    import ifu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [6:0]         opcode,
    output logic [3:0]         funct
);

    logic unused_bits;

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct  = {instr[FUNCT7_ALT_BIT], instr[FUNCT3_MSB:FUNCT3_LSB]};

    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch unit with branch redirect and a held decode slot.
// Define IFU_MISALIGN_TRAP_EN to add the misalign output and ignore misaligned redirects.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc_out,
    output logic [6:0]         Opcode,
    output logic [3:0]         Funct
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic               misalign
`endif
);

    ifu_state_e      state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt, redirect_pc;
    logic            discard, discard_nxt;
    logic            out_valid_nxt;
    logic            load;
    logic            redirect;
    logic            can_issue;

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_nxt;

    assign misalign_nxt = branch_taken && (branch_target[1:0] != 2'b00);
    assign redirect     = branch_taken && !misalign_nxt;
    assign redirect_pc  = branch_target;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= misalign_nxt;
        end
    end
`else
    assign redirect    = branch_taken;
    assign redirect_pc = branch_target & ~PC_W'(3);
`endif

    // A new request may only go out if the decode slot is free or drains this cycle
    assign can_issue = !out_valid || out_ready;
    assign imem_addr = pc;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        discard_nxt = discard;
        imem_req    = 1'b0;
        load        = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = can_issue;
                if (can_issue && imem_gnt) begin
                    state_nxt   = WAIT;
                    discard_nxt = redirect;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt   = FETCH;
                    discard_nxt = 1'b0;
                    load        = !discard && !redirect;
                    if (load) begin
                        pc_nxt = pc + PC_W'(PC_INC);
                    end
                end else if (redirect) begin
                    discard_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (redirect) begin
            pc_nxt = redirect_pc;
        end

        // Redirect flushes the held word even if decode is not taking it
        if (redirect) begin
            out_valid_nxt = 1'b0;
        end else if (load) begin
            out_valid_nxt = 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end else begin
            out_valid_nxt = out_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            discard   <= 1'b0;
            out_valid <= 1'b0;
            instr     <= '0;
            pc_out    <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            discard   <= discard_nxt;
            out_valid <= out_valid_nxt;
            if (load) begin
                instr  <= imem_rdata;
                pc_out <= pc;
            end
        end
    end

    instruction_parser u_parser (
        .instr  (instr),
        .opcode (Opcode),
        .funct  (Funct)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory responder plus in-order scoreboard
// of expected {pc, word} pairs, compared when decode consumes a held instruction.
module tb_instruction_fetch_unit;

    localparam int          PC_W     = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [63:0] pc_out;
    logic [6:0]  Opcode;
    logic [3:0]  Funct;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    instruction_fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .instr         (instr),
        .pc_out        (pc_out),
        .Opcode        (Opcode),
        .Funct         (Funct)
`ifdef IFU_MISALIGN_TRAP_EN
        ,
        .misalign      (misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          consumed = 0;

    logic        pending;
    logic [63:0] pend_addr;
    logic        squash;
    logic        gnt_en;
    logic        rvalid_en;
    logic [63:0] exp_pc;
    logic        ovr_en;
    logic [31:0] ovr_word;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h6F2A_1C93;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: decode-side checks and memory drive at negedge, return at posedge+1
    task automatic cycle();
        exp_t        e;
        logic        br;
        logic [63:0] tgt;
        @(negedge clk);
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'(out_valid), 64'd0);
            end else if (out_ready) begin
                e = sb.pop_front();
                consumed++;
                chk("instr", 64'(instr), 64'(e.word));
                chk("pc_out", pc_out, e.pc);
                chk("opcode", 64'(Opcode), 64'(e.word[6:0]));
                chk("funct", 64'(Funct), 64'({e.word[30], e.word[14:12]}));
            end else begin
                chk("hold_instr", 64'(instr), 64'(sb[0].word));
                chk("hold_pc", pc_out, sb[0].pc);
            end
        end

        imem_gnt    = imem_req && gnt_en;
        imem_rvalid = pending && rvalid_en;
        imem_rdata  = ovr_en ? ovr_word : mem_word(pend_addr);
        if (imem_gnt) chk("fetch_addr", imem_addr, exp_pc);

`ifdef IFU_MISALIGN_TRAP_EN
        br  = branch_taken && reset && (branch_target[1:0] == 2'b00);
        tgt = branch_target;
`else
        br  = branch_taken && reset;
        tgt = {branch_target[63:2], 2'b00};
`endif
        if (imem_rvalid) begin
            if (!squash && !br && reset) begin
                sb.push_back(exp_t'{pend_addr, imem_rdata});
                exp_pc = exp_pc + 64'd4;
            end
            pending = 1'b0;
            squash  = 1'b0;
        end
        if (imem_gnt) begin
            pending   = 1'b1;
            pend_addr = imem_addr;
            squash    = 1'b0;
        end
        if (br) begin
            exp_pc = tgt;
            sb.delete();
            if (pending) squash = 1'b1;
        end
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_pending(input string tag, input int budget);
        int n = 0;
        while (!pending && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 64'(pending), 64'd1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (imem_req !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 64'(imem_req), 64'd1);
    endtask

    task automatic run_consumed(input string tag, input int cnt, input int budget);
        int start = consumed;
        int n = 0;
        while (consumed - start < cnt && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 64'(consumed - start), 64'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        out_ready     = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        pending       = 1'b0;
        pend_addr     = 64'h0;
        squash        = 1'b0;
        gnt_en        = 1'b1;
        rvalid_en     = 1'b1;
        exp_pc        = RESET_PC;
        ovr_en        = 1'b0;
        ovr_word      = 32'h0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc_out", pc_out, 64'd0);
        cycle();
        cycle();
        reset = 1'b1;
        chk("idle_req", 64'(imem_req), 64'd0);
        cycle();
        chk("fetch_req", 64'(imem_req), 64'd1);

        // Streaming fetch 0,4,8,... with decode always ready
        run_consumed("stream", 6, 40);

        // Decode stall: request withheld, held word stable
        out_ready = 1'b0;
        wait_valid("stall_valid", 10);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_req", 64'(imem_req), 64'd0);
            chk("stall_hold", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        run_consumed("resume", 3, 20);

        // Field extraction on a known word
        out_ready = 1'b0;
        wait_valid("pre_field", 10);
        ovr_en    = 1'b1;
        ovr_word  = 32'h40B5_0533;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        wait_valid("field_valid", 10);
        chk("field_opcode", 64'(Opcode), 64'h33);
        chk("field_funct", 64'(Funct), 64'h8);
        ovr_en    = 1'b0;
        out_ready = 1'b1;
        run_consumed("field_drain", 2, 20);

        // Branch flushes a held word even while decode is stalled
        out_ready = 1'b0;
        wait_valid("pre_flush", 10);
        branch_target = 64'h400;
        branch_taken  = 1'b1;
        cycle();
        chk("flush_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        run_consumed("after_flush", 2, 20);

        // Branch in FETCH before grant retargets the request; low bits forced to 0
        gnt_en = 1'b0;
        wait_req("pre_retarget", 10);
        branch_target = 64'h2002;
        branch_taken  = 1'b1;
        cycle();
        chk("retarget_addr", imem_addr, 64'h2000);
        chk("retarget_req", 64'(imem_req), 64'd1);
        gnt_en = 1'b1;
        run_consumed("after_retarget", 2, 20);

        // Branch during WAIT drops the pending word
        rvalid_en = 1'b0;
        wait_pending("pre_wait_branch", 10);
        branch_target = 64'h100;
        branch_taken  = 1'b1;
        cycle();
        rvalid_en = 1'b1;
        cycle();
        wait_valid("wait_branch_valid", 10);
        chk("wait_branch_pc", pc_out, 64'h100);
        chk("wait_branch_instr", 64'(instr), 64'(mem_word(64'h100)));
        run_consumed("after_wait_branch", 2, 20);

        // PC wraps modulo 2^64
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        branch_taken  = 1'b1;
        cycle();
        wait_valid("wrap_first", 10);
        chk("wrap_top_pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        run_consumed("wrap", 3, 20);

        // Reset during WAIT, stale response after release is ignored
        rvalid_en = 1'b0;
        wait_pending("pre_reset", 10);
        reset  = 1'b0;
        sb.delete();
        exp_pc = RESET_PC;
        if (pending) squash = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        chk("mid_rst_instr", 64'(instr), 64'd0);
        cycle();
        reset     = 1'b1;
        rvalid_en = 1'b1;
        chk("idle_req2", 64'(imem_req), 64'd0);
        cycle();
        chk("stale_valid", 64'(out_valid), 64'd0);
        wait_valid("post_rst_valid", 10);
        chk("post_rst_pc", pc_out, RESET_PC);
        run_consumed("post_rst", 3, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
